// File: rtl/cnn_fmap_pkg.sv
// rtl/cnn_fmap_pkg.sv - shared defaults, output count and FSM encoding for the feature-map window scheduler
package cnn_fmap_pkg;

    localparam int DEF_IMG_W  = 128;
    localparam int DEF_IMG_H  = 128;
    localparam int DEF_K      = 3;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    // Number of valid-convolution outputs for a stride-1, unpadded pass.
    function automatic int calc_nout(input int w, input int h, input int k);
        return (w - k + 1) * (h - k + 1);
    endfunction

    localparam int NOUT = calc_nout(DEF_IMG_W, DEF_IMG_H, DEF_K);

endpackage

// File: rtl/fmap_win_addr_gen.sv
// rtl/fmap_win_addr_gen.sv - raster KxK window walker producing read addresses by incremental adds
module fmap_win_addr_gen #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int K      = 3,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        ky,
    output logic [1:0]        kx,
    output logic              last,
    output logic              final_tap
);
    localparam int SW = ADDR_W + 1;

    logic [SW-1:0] win_base;
    logic [SW-1:0] row_base;
    logic [SW-1:0] ox;
    logic [SW-1:0] oy;
    logic [SW-1:0] sum;

    // row_base tracks (oy+ky)*IMG_W; win_base tracks oy*IMG_W for the window's top row.
    assign sum       = row_base + ox + {{(SW-2){1'b0}}, kx};
    assign addr      = sum[ADDR_W-1:0];
    assign last      = (kx == 2'(K - 1)) && (ky == 2'(K - 1));
    assign final_tap = last && (ox == SW'(IMG_W - K)) && (oy == SW'(IMG_H - K));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_base <= '0;
            row_base <= '0;
            ox       <= '0;
            oy       <= '0;
            ky       <= '0;
            kx       <= '0;
        end else if (clear) begin
            win_base <= '0;
            row_base <= '0;
            ox       <= '0;
            oy       <= '0;
            ky       <= '0;
            kx       <= '0;
        end else if (adv) begin
            if (kx != 2'(K - 1)) begin
                kx <= kx + 2'd1;
            end else begin
                kx <= '0;
                if (ky != 2'(K - 1)) begin
                    ky       <= ky + 2'd1;
                    row_base <= row_base + SW'(IMG_W);
                end else begin
                    ky <= '0;
                    if (ox != SW'(IMG_W - K)) begin
                        ox       <= ox + SW'(1);
                        row_base <= win_base;
                    end else begin
                        ox <= '0;
                        if (oy != SW'(IMG_H - K)) begin
                            oy       <= oy + SW'(1);
                            win_base <= win_base + SW'(IMG_W);
                            row_base <= win_base + SW'(IMG_W);
                        end else begin
                            oy       <= '0;
                            win_base <= '0;
                            row_base <= '0;
                        end
                    end
                end
            end
        end
    end

    a_no_addr_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(adv && sum[ADDR_W]));

endmodule

// File: rtl/fmap_window_sched.sv
// rtl/fmap_window_sched.sv - convolution pass sequencer: window reads, tap tagging and dense result write-back
module fmap_window_sched
    import cnn_fmap_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              tap_valid,
    output logic [1:0]        tap_ky,
    output logic [1:0]        tap_kx,
    output logic              tap_last,
    input  logic              res_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              we,
    output logic              busy,
    output logic              done
);
    localparam int NOUT_P = calc_nout(IMG_W, IMG_H, K);
    localparam int CW     = ADDR_W + 1;

    if ((2 ** ADDR_W) < (IMG_W * IMG_H)) begin : g_addr_w_check
        $error("ADDR_W too small to address IMG_W*IMG_H pixels");
    end
    if ((K < 1) || (K > 4) || (RD_LAT < 1)) begin : g_param_check
        $error("K must be 1..4 and RD_LAT at least 1");
    end

    fsm_state_t state, state_nx;

    logic              start_acc;
    logic              last;
    logic              final_tap;
    logic [1:0]        ky;
    logic [1:0]        kx;
    logic [CW-1:0]     wcount;
    logic              writes_done;
    logic              pipe_empty;

    logic [RD_LAT-1:0]      pv;
    logic [RD_LAT-1:0]      pl;
    logic [RD_LAT-1:0][1:0] pky;
    logic [RD_LAT-1:0][1:0] pkx;

    assign start_acc = start && (state == ST_IDLE);
    assign rd_en     = (state == ST_RUN) && out_ready;
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);

    fmap_win_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (start_acc),
        .adv       (rd_en),
        .addr      (rd_addr),
        .ky        (ky),
        .kx        (kx),
        .last      (last),
        .final_tap (final_tap)
    );

    // Tags ride alongside the RAM read so they line up with data_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv  <= '0;
            pl  <= '0;
            pky <= '0;
            pkx <= '0;
        end else begin
            pv[0]  <= rd_en;
            pl[0]  <= rd_en && last;
            pky[0] <= rd_en ? ky : 2'd0;
            pkx[0] <= rd_en ? kx : 2'd0;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i]  <= pv[i-1];
                pl[i]  <= pl[i-1];
                pky[i] <= pky[i-1];
                pkx[i] <= pkx[i-1];
            end
        end
    end

    assign tap_valid  = pv[RD_LAT-1];
    assign tap_last   = pl[RD_LAT-1];
    assign tap_ky     = pky[RD_LAT-1];
    assign tap_kx     = pkx[RD_LAT-1];
    assign pipe_empty = ~|pv;

    // Write count saturates at NOUT; writes_done counts this cycle's write so done trails the last result by one cycle.
    assign we          = res_valid && busy && (wcount != CW'(NOUT_P));
    assign wr_addr     = wcount[ADDR_W-1:0];
    assign writes_done = (wcount == CW'(NOUT_P)) || (we && (wcount == CW'(NOUT_P - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcount <= '0;
        end else if (start_acc) begin
            wcount <= '0;
        end else if (we) begin
            wcount <= wcount + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (rd_en && final_tap) state_nx = ST_DRAIN;
            ST_DRAIN: if (pipe_empty && writes_done) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fmap_window_sched.sv
// tb/tb_fmap_window_sched.sv - scoreboard bench for fmap_window_sched on a 5x4 map with a 3x3 kernel
module tb_fmap_window_sched;
    localparam int W     = 5;
    localparam int H     = 4;
    localparam int KK    = 3;
    localparam int AW    = 14;
    localparam int NOUT  = 6;
    localparam int NTAPS = 54;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          res_valid = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          rd_en, tap_valid, tap_last, we, busy, done;
    logic [1:0]    tap_ky, tap_kx;

    always #5 clk = ~clk;

    fmap_window_sched #(
        .IMG_W (W), .IMG_H (H), .K (KK), .ADDR_W (AW), .RD_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .out_ready (out_ready),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .tap_valid (tap_valid),
        .tap_ky    (tap_ky),
        .tap_kx    (tap_kx),
        .tap_last  (tap_last),
        .res_valid (res_valid),
        .wr_addr   (wr_addr),
        .we        (we),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int addr;
        int ky;
        int kx;
        bit last;
    } tap_t;

    int   tests = 0;
    int   fails = 0;
    tap_t addr_q[$];
    tap_t tag_q[$];
    int   rd_hist[$];
    int   m_state, m_issued, wcnt;
    bit   prev_rden;
    int   n_rd, n_tap, n_last, n_we, n_done, last_addr;

    task automatic fill_exp();
        tap_t t;
        addr_q.delete();
        tag_q.delete();
        for (int oy = 0; oy <= H - KK; oy++)
            for (int ox = 0; ox <= W - KK; ox++)
                for (int ky = 0; ky < KK; ky++)
                    for (int kx = 0; kx < KK; kx++) begin
                        t.addr = (oy + ky) * W + ox + kx;
                        t.ky   = ky;
                        t.kx   = kx;
                        t.last = (ky == KK - 1) && (kx == KK - 1);
                        addr_q.push_back(t);
                    end
    endtask

    task automatic clear_stats();
        n_rd = 0; n_tap = 0; n_last = 0; n_we = 0; n_done = 0; last_addr = -1;
        rd_hist.delete();
    endtask

    task automatic apply_reset(input bit rv);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; out_ready = 1'b0; res_valid = rv;
        m_state = 0; m_issued = 0; wcnt = 0; prev_rden = 1'b0;
        addr_q.delete();
        tag_q.delete();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1; res_valid = 1'b0;
    endtask

    // One clock of stimulus; the reference model predicts, the scoreboard queues supply addresses and tags.
    task automatic step(input bit st, input bit ordy, input bit rv);
        tap_t          e;
        bit            e_busy, e_done, e_rden, e_tapv, e_we;
        logic [AW-1:0] ea;
        @(negedge clk);
        start = st; out_ready = ordy; res_valid = rv;
        #1;
        e_busy = (m_state == 1) || (m_state == 2);
        e_done = (m_state == 3);
        e_rden = (m_state == 1) && ordy;
        e_tapv = prev_rden;
        e_we   = rv && e_busy && (wcnt < NOUT);
        tests += 5;
        if (rd_en !== e_rden) begin fails++; $display("FAIL rd_en: got %b want %b", rd_en, e_rden); end
        if (busy !== e_busy) begin fails++; $display("FAIL busy: got %b want %b", busy, e_busy); end
        if (done !== e_done) begin fails++; $display("FAIL done: got %b want %b", done, e_done); end
        if (tap_valid !== e_tapv) begin fails++; $display("FAIL tap_valid: got %b want %b", tap_valid, e_tapv); end
        if (we !== e_we) begin fails++; $display("FAIL we: got %b want %b", we, e_we); end
        if (rd_en === 1'b1) begin n_rd++; last_addr = int'(rd_addr); rd_hist.push_back(int'(rd_addr)); end
        if (tap_valid === 1'b1) begin n_tap++; if (tap_last === 1'b1) n_last++; end
        if (we === 1'b1) n_we++;
        if (done === 1'b1) n_done++;
        if (e_rden) begin
            tests++;
            if (addr_q.size() == 0) begin
                fails++; $display("FAIL rd_addr_queue: got extra read want none");
            end else begin
                e  = addr_q.pop_front();
                tag_q.push_back(e);
                ea = AW'(e.addr);
                if (rd_addr !== ea) begin fails++; $display("FAIL rd_addr: got %0d want %0d", rd_addr, ea); end
            end
            m_issued++;
        end
        if (e_tapv) begin
            tests++;
            if (tag_q.size() == 0) begin
                fails++; $display("FAIL tap_queue: got extra tap want none");
            end else begin
                e = tag_q.pop_front();
                if (int'(tap_ky) != e.ky || int'(tap_kx) != e.kx || tap_last !== e.last) begin
                    fails++;
                    $display("FAIL tap_tag: got ky=%0d kx=%0d last=%b want ky=%0d kx=%0d last=%b",
                             tap_ky, tap_kx, tap_last, e.ky, e.kx, e.last);
                end
            end
        end
        if (e_we) begin
            tests++;
            ea = AW'(wcnt);
            if (wr_addr !== ea) begin fails++; $display("FAIL wr_addr: got %0d want %0d", wr_addr, ea); end
            wcnt++;
        end
        prev_rden = e_rden;
        case (m_state)
            0: if (st) begin m_state = 1; m_issued = 0; wcnt = 0; fill_exp(); end
            1: if (m_issued == NTAPS) m_state = 2;
            2: if (!e_tapv && wcnt == NOUT) m_state = 3;
            default: m_state = 0;
        endcase
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        tests++;
        if (rd_addr !== '0 || rd_en !== 1'b0 || tap_valid !== 1'b0 || tap_ky !== 2'd0 || tap_kx !== 2'd0 ||
            tap_last !== 1'b0 || wr_addr !== '0 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: got addr=%0d rd_en=%b tv=%b wa=%0d we=%b busy=%b done=%b want all zero",
                     rd_addr, rd_en, tap_valid, wr_addr, we, busy, done);
        end
        release_reset();
        step(1'b0, 1'b1, 1'b1);
        tests++;
        if (we !== 1'b0 || rd_en !== 1'b0) begin
            fails++; $display("FAIL idle_quiet: got we=%b rd_en=%b want 0 0", we, rd_en);
        end
    endtask

    task automatic test_raster();
        int exp_first[18] = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 1, 2, 3, 6, 7, 8, 11, 12, 13};
        clear_stats();
        for (int i = 0; i < 150; i++) begin
            step(i == 0, 1'b1, (i >= 56 && i < 62));
            if (n_done > 0) break;
        end
        tests += 5;
        if (n_rd != NTAPS) begin fails++; $display("FAIL raster_reads: got %0d want %0d", n_rd, NTAPS); end
        if (last_addr != 19) begin fails++; $display("FAIL raster_last_addr: got %0d want 19", last_addr); end
        if (n_tap != NTAPS) begin fails++; $display("FAIL raster_taps: got %0d want %0d", n_tap, NTAPS); end
        if (n_last != NOUT) begin fails++; $display("FAIL raster_tap_last: got %0d want %0d", n_last, NOUT); end
        if (n_done != 1) begin fails++; $display("FAIL raster_done: got %0d want 1", n_done); end
        for (int i = 0; i < 18; i++) begin
            tests++;
            if (rd_hist.size() <= i) begin
                fails++; $display("FAIL raster_seq[%0d]: got none want %0d", i, exp_first[i]);
            end else if (rd_hist[i] != exp_first[i]) begin
                fails++; $display("FAIL raster_seq[%0d]: got %0d want %0d", i, rd_hist[i], exp_first[i]);
            end
        end
    endtask

    task automatic test_tap_tags();
        clear_stats();
        for (int i = 0; i < 400; i++) begin
            step(i == 0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            if (n_done > 0) break;
        end
        tests += 3;
        if (n_tap != NTAPS) begin fails++; $display("FAIL tags_taps: got %0d want %0d", n_tap, NTAPS); end
        if (n_last != NOUT) begin fails++; $display("FAIL tags_last: got %0d want %0d", n_last, NOUT); end
        if (n_done != 1) begin fails++; $display("FAIL tags_done: got %0d want 1", n_done); end
    endtask

    task automatic test_stall();
        clear_stats();
        for (int i = 0; i < 200; i++) begin
            step(i == 0, !(i >= 5 && i <= 8), (i >= 70 && i < 76));
            if (i >= 5 && i <= 8) begin
                tests++;
                if (rd_en !== 1'b0 || rd_addr !== AW'(6)) begin
                    fails++; $display("FAIL stall_hold: got rd_en=%b addr=%0d want 0 6", rd_en, rd_addr);
                end
            end
            if (i == 5) begin
                tests++;
                if (tap_valid !== 1'b1 || tap_ky !== 2'd1 || tap_kx !== 2'd0) begin
                    fails++; $display("FAIL stall_inflight_tap: got tv=%b ky=%0d kx=%0d want 1 1 0", tap_valid, tap_ky, tap_kx);
                end
            end
            if (i == 9) begin
                tests++;
                if (rd_en !== 1'b1 || rd_addr !== AW'(6)) begin
                    fails++; $display("FAIL stall_resume: got rd_en=%b addr=%0d want 1 6", rd_en, rd_addr);
                end
            end
            if (n_done > 0) break;
        end
        tests += 2;
        if (n_rd != NTAPS) begin fails++; $display("FAIL stall_reads: got %0d want %0d", n_rd, NTAPS); end
        if (n_done != 1) begin fails++; $display("FAIL stall_done: got %0d want 1", n_done); end
    endtask

    task automatic test_results();
        int  done_step = -1;
        bit  rv;
        clear_stats();
        for (int i = 0; i < 150; i++) begin
            rv = (i == 6) || (i == 16) || (i == 26) || (i == 36) || (i == 46) || (i == 51) || (i == 53) || (i == 54);
            step(i == 0, 1'b1, rv);
            if (done === 1'b1 && done_step < 0) done_step = i;
            if (n_done > 0) break;
        end
        tests += 3;
        if (n_we != NOUT) begin fails++; $display("FAIL results_writes: got %0d want %0d", n_we, NOUT); end
        if (n_done != 1) begin fails++; $display("FAIL results_done_count: got %0d want 1", n_done); end
        if (done_step != 57) begin fails++; $display("FAIL results_done_cycle: got %0d want 57", done_step); end
    endtask

    task automatic test_withheld();
        int done_step = -1;
        clear_stats();
        for (int i = 0; i < 150; i++) begin
            step(i == 0, 1'b1, (i >= 65 && i <= 70));
            if (i >= 56 && i <= 64) begin
                tests++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    fails++; $display("FAIL withheld_wait: got busy=%b done=%b want 1 0", busy, done);
                end
            end
            if (done === 1'b1 && done_step < 0) done_step = i;
            if (n_done > 0) break;
        end
        tests++;
        if (done_step != 71) begin fails++; $display("FAIL withheld_done_cycle: got %0d want 71", done_step); end
    endtask

    task automatic test_reset_midpass();
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            step((i == 0) || (i == 10), 1'b1, (i == 5) || (i == 8));
        end
        apply_reset(1'b1);
        tests++;
        if (rd_addr !== '0 || rd_en !== 1'b0 || tap_valid !== 1'b0 || tap_last !== 1'b0 || wr_addr !== '0 ||
            we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midpass_reset: got addr=%0d rd_en=%b tv=%b wa=%0d we=%b busy=%b done=%b want all zero",
                     rd_addr, rd_en, tap_valid, wr_addr, we, busy, done);
        end
        release_reset();
        clear_stats();
        for (int i = 0; i < 150; i++) begin
            step(i == 0, 1'b1, (i == 1) || (i >= 60 && i < 66));
            if (i == 1) begin
                tests++;
                if (rd_en !== 1'b1 || rd_addr !== '0 || we !== 1'b1 || wr_addr !== '0) begin
                    fails++;
                    $display("FAIL restart_first: got rd_en=%b addr=%0d we=%b wa=%0d want 1 0 1 0", rd_en, rd_addr, we, wr_addr);
                end
            end
            if (n_done > 0) break;
        end
        tests++;
        if (n_done != 1) begin fails++; $display("FAIL restart_done: got %0d want 1", n_done); end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_tap_tags();
        test_stall();
        test_results();
        test_withheld();
        test_reset_midpass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
